// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register with a two-entry skid buffer.
// Moves a control bundle and a data bundle between stages over a valid/ready
// handshake. The main slot drives the outputs directly from flops; the skid
// slot catches the beat that arrives while the main slot is stalled, which lets
// in_ready be a pure flop output (no out_ready -> in_ready path) while still
// sustaining one beat per cycle. Control is zeroed in the stored registers
// whenever a slot empties, so downstream never sees live control on a bubble.
module pipe_stage_skid #(
  parameter int CTRL_W    = 8,
  parameter int DATA_W    = 64,
  parameter int ZERO_DATA = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  logic              main_valid_q, main_valid_d;
  logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
  logic [DATA_W-1:0] main_data_q,  main_data_d;
  logic              skid_valid_q, skid_valid_d;
  logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;
  logic              in_fire;
  logic              out_fire;

  // Outputs come straight from the stored state; in_ready only depends on the skid flop.
  assign in_ready  = ~skid_valid_q;
  assign out_valid = main_valid_q;
  assign out_ctrl  = main_ctrl_q;
  assign out_data  = main_data_q;
  assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

  // Next-state for both slots: flush wins, then skid drain, then main-slot traffic.
  always_comb begin
    in_fire      = in_valid & ~skid_valid_q;
    out_fire     = main_valid_q & out_ready;
    main_valid_d = main_valid_q;
    main_ctrl_d  = main_ctrl_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_ctrl_d  = skid_ctrl_q;
    skid_data_d  = skid_data_q;

    if (flush) begin
      main_valid_d = 1'b0;
      main_ctrl_d  = '0;
      skid_valid_d = 1'b0;
      skid_ctrl_d  = '0;
      if (ZERO_DATA != 0) begin
        main_data_d = '0;
        skid_data_d = '0;
      end
    end else if (skid_valid_q) begin
      if (out_fire) begin
        main_valid_d = 1'b1;
        main_ctrl_d  = skid_ctrl_q;
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
        skid_ctrl_d  = '0;
        if (ZERO_DATA != 0) begin
          skid_data_d = '0;
        end
      end
    end else if (main_valid_q) begin
      if (in_fire && out_fire) begin
        main_ctrl_d = in_ctrl;
        main_data_d = in_data;
      end else if (out_fire) begin
        main_valid_d = 1'b0;
        main_ctrl_d  = '0;
        if (ZERO_DATA != 0) begin
          main_data_d = '0;
        end
      end else if (in_fire) begin
        skid_valid_d = 1'b1;
        skid_ctrl_d  = in_ctrl;
        skid_data_d  = in_data;
      end
    end else if (in_fire) begin
      main_valid_d = 1'b1;
      main_ctrl_d  = in_ctrl;
      main_data_d  = in_data;
    end
  end

  // Slot registers; reset empties both slots and clears all payload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_ctrl_q  <= '0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_ctrl_q  <= '0;
      skid_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_ctrl_q  <= main_ctrl_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_ctrl_q  <= skid_ctrl_d;
      skid_data_q  <= skid_data_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: two instances (data-holding and data-zeroing)
// share one stimulus stream; a queue-based scoreboard tracks the beats that
// should be held and checks both instances every cycle.
module tb_pipe_stage_skid;

  localparam int CW = 8;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          inValid = 1'b0;
  logic [CW-1:0] inCtrl = '0;
  logic [DW-1:0] inData = '0;
  logic          outReady = 1'b0;

  logic          inReadyH, outValidH, inReadyZ, outValidZ;
  logic [CW-1:0] outCtrlH, outCtrlZ;
  logic [DW-1:0] outDataH, outDataZ;
  logic [1:0]    occH, occZ;

  typedef struct {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } beat_t;

  beat_t         model[$];
  logic [DW-1:0] lastHead = '0;
  int            vectors = 0;
  int            miscompares = 0;
  logic          readyWas = 1'b1;

  always #5 clk = ~clk;

  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .ZERO_DATA(0)) dutHold (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(inValid), .in_ready(inReadyH), .in_ctrl(inCtrl), .in_data(inData),
    .out_valid(outValidH), .out_ready(outReady), .out_ctrl(outCtrlH), .out_data(outDataH),
    .occupancy(occH)
  );

  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .ZERO_DATA(1)) dutZero (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(inValid), .in_ready(inReadyZ), .in_ctrl(inCtrl), .in_data(inData),
    .out_valid(outValidZ), .out_ready(outReady), .out_ctrl(outCtrlZ), .out_data(outDataZ),
    .occupancy(occZ)
  );

  // One comparison: counts it, reports a FAIL line on mismatch.
  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one cycle of inputs from just after a rising edge to just after the next.
  task automatic applyStimulus(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                               input logic ordy, input logic fl);
    inValid  = v;
    inCtrl   = c;
    inData   = d;
    outReady = ordy;
    flush    = fl;
    @(negedge clk);
    readyWas = inReadyH;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: compare mid-cycle against the beat queue, then advance it with the inputs.
  always @(negedge clk) begin
    if (rst) begin
      checkOutput("rst_out_valid", {63'd0, outValidH}, 64'd0);
      checkOutput("rst_in_ready", {63'd0, inReadyH}, 64'd1);
      checkOutput("rst_out_ctrl", {56'd0, outCtrlH}, 64'd0);
      checkOutput("rst_out_data", outDataH, 64'd0);
      checkOutput("rst_occupancy", {62'd0, occH}, 64'd0);
      checkOutput("rst_z_out_valid", {63'd0, outValidZ}, 64'd0);
      model.delete();
      lastHead = '0;
    end else begin
      logic       expValid, expReady, inFire, outFire;
      logic [CW-1:0] expCtrl;
      logic [DW-1:0] expData;
      expValid = (model.size() > 0);
      expReady = (model.size() < 2);
      expCtrl  = expValid ? model[0].c : '0;
      expData  = expValid ? model[0].d : lastHead;
      checkOutput("out_valid", {63'd0, outValidH}, {63'd0, expValid});
      checkOutput("in_ready", {63'd0, inReadyH}, {63'd0, expReady});
      checkOutput("occupancy", {62'd0, occH}, 64'(model.size()));
      checkOutput("out_ctrl", {56'd0, outCtrlH}, {56'd0, expCtrl});
      checkOutput("out_data_hold", outDataH, expData);
      checkOutput("z_out_valid", {63'd0, outValidZ}, {63'd0, expValid});
      checkOutput("z_in_ready", {63'd0, inReadyZ}, {63'd0, expReady});
      checkOutput("z_occupancy", {62'd0, occZ}, 64'(model.size()));
      checkOutput("z_out_ctrl", {56'd0, outCtrlZ}, {56'd0, expCtrl});
      checkOutput("z_out_data", outDataZ, expValid ? model[0].d : 64'd0);

      inFire  = inValid && expReady;
      outFire = expValid && outReady;
      if (flush) begin
        model.delete();
      end else begin
        if (outFire) void'(model.pop_front());
        if (inFire) model.push_back('{c: inCtrl, d: inData});
      end
      if (model.size() > 0) lastHead = model[0].d;
    end
  end

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Fill to two beats, then reset mid-stream; first beat after release shows next cycle.
    applyStimulus(1'b1, 8'h11, 64'h100, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h22, 64'h200, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h77, 64'h700, 1'b0, 1'b0);
    rst = 1'b1;
    applyStimulus(1'b0, 8'h00, 64'h0, 1'b0, 1'b0);
    rst = 1'b0;
    applyStimulus(1'b1, 8'hA5, 64'h1, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 64'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 64'h0, 1'b1, 1'b0);

    // Back-to-back streaming with the consumer always ready.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 8'(i + 1), 64'(i), 1'b1, 1'b0);
    end
    applyStimulus(1'b0, 8'h00, 64'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 64'h0, 1'b1, 1'b0);

    // Backpressure: beat 2 stalls at the input until the skid drains.
    applyStimulus(1'b1, 8'hC0, 64'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hC1, 64'h1, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hC2, 64'h2, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hC2, 64'h2, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hC2, 64'h2, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'hC2, 64'h2, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 64'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 64'h0, 1'b1, 1'b0);

    // Flush with two beats held and a new beat offered; nothing survives.
    applyStimulus(1'b1, 8'h0F, 64'hF00, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hF0, 64'h0F0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h33, 64'h333, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 64'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 64'h0, 1'b1, 1'b0);

    // Bubble after a single drained beat: control zero, data held or zeroed.
    applyStimulus(1'b1, 8'hFF, 64'hDEAD, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 64'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 64'h0, 1'b1, 1'b0);

    // Random traffic; a stalled beat is held stable until accepted or flushed.
    for (int cyc = 0; cyc < 10000; cyc++) begin
      logic          v, ordy, fl;
      logic [CW-1:0] c;
      logic [DW-1:0] d;
      if (inValid && !readyWas && !flush) begin
        v = 1'b1;
        c = inCtrl;
        d = inData;
      end else begin
        v = ($urandom_range(0, 99) < 60);
        c = 8'($urandom);
        d = {$urandom, $urandom};
      end
      ordy = ($urandom_range(0, 99) < 60);
      fl   = ($urandom_range(0, 99) < 5);
      applyStimulus(v, c, d, ordy, fl);
    end
    applyStimulus(1'b0, 8'h00, 64'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 64'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 64'h0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
